// File: rtl/pong_pkg.sv
// Shared types and default frame geometry for the pong datapath, video timing and sequencer.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int unsigned H_LAST_DEFAULT = 1023;
    localparam int unsigned V_LAST_DEFAULT = 767;

    localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/frame_divider.sv
// Counts frame_end strobes and emits a registered one-cycle pulse on every Nth one.
module frame_divider #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic frame_end,
    output logic pulse,
    output logic wrap
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count_q, count_d;
    logic         pulse_d;

    // Combinational view of the terminal frame, so the FSM can change state on the same edge.
    assign wrap = frame_end && !clear && (count_q == W'(N - 1));

    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (frame_end) begin
            if (wrap) begin
                count_d = '0;
                pulse_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            pulse   <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse   <= pulse_d;
        end
    end

endmodule

// File: rtl/pong_sequencer.sv
// Round sequencer for pong: frame timing, movement ticks, serve delay, score and lives.
module pong_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned H_LAST          = H_LAST_DEFAULT,
    parameter int unsigned V_LAST          = V_LAST_DEFAULT,
    parameter int unsigned FRAMES_PER_TICK = 4,
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned LIVES           = 3
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        hit_in,
    input  logic        miss_in,
    output logic        tick_out,
    output logic        serve_out,
    output logic [1:0]  state_out,
    output logic [7:0]  score_out,
    output logic [3:0]  lives_out,
    output logic        game_over_out
);

    game_state_t state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  lives_q, lives_d;
    logic        start_q;
    logic        game_over_q;

    logic frame_end;
    logic start_rise;
    logic serve_clear, tick_clear;
    logic serve_fe, tick_fe;
    logic serve_wrap;
    logic unused_tick_wrap;

    assign frame_end  = (hcount_in == 11'(H_LAST)) && (vcount_in == 10'(V_LAST));
    assign start_rise = start_in && !start_q;

    // A miss on the tick frame must not produce a tick, so it never reaches the divider.
    assign serve_fe = frame_end && (state_q == SERVE);
    assign tick_fe  = frame_end && (state_q == PLAY) && !miss_in;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_d = SERVE;
                    score_d = '0;
                    lives_d = 4'(LIVES);
                end
            end
            SERVE: begin
                if (serve_wrap) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (miss_in) begin
                    if (lives_q <= 4'd1) begin
                        lives_d = '0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 4'd1;
                        state_d = SERVE;
                    end
                end else if (hit_in && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign serve_clear = (state_d == SERVE) && (state_q != SERVE);
    assign tick_clear  = (state_d == PLAY) && (state_q != PLAY);

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            score_q     <= '0;
            lives_q     <= 4'(LIVES);
            start_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            start_q     <= start_in;
            game_over_q <= (state_d == OVER);
        end
    end

    frame_divider #(
        .N (SERVE_FRAMES)
    ) u_serve_div (
        .clk       (pixel_clk_in),
        .rst       (rst_in),
        .clear     (serve_clear),
        .frame_end (serve_fe),
        .pulse     (serve_out),
        .wrap      (serve_wrap)
    );

    frame_divider #(
        .N (FRAMES_PER_TICK)
    ) u_tick_div (
        .clk       (pixel_clk_in),
        .rst       (rst_in),
        .clear     (tick_clear),
        .frame_end (tick_fe),
        .pulse     (tick_out),
        .wrap      (unused_tick_wrap)
    );

    assign state_out     = state_q;
    assign score_out     = score_q;
    assign lives_out     = lives_q;
    assign game_over_out = game_over_q;

endmodule

// File: tb/tb_pong_sequencer.sv
// Directed self-checking bench for pong_sequencer with SERVE_FRAMES=2, FRAMES_PER_TICK=4, LIVES=3.
module tb_pong_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        start, hit, miss;
    logic        tick, serve;
    logic [1:0]  state;
    logic [7:0]  score;
    logic [3:0]  lives;
    logic        game_over;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    always #5 clk = ~clk;

    pong_sequencer #(
        .H_LAST          (1023),
        .V_LAST          (767),
        .FRAMES_PER_TICK (4),
        .SERVE_FRAMES    (2),
        .LIVES           (3)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .start_in      (start),
        .hit_in        (hit),
        .miss_in       (miss),
        .tick_out      (tick),
        .serve_out     (serve),
        .state_out     (state),
        .score_out     (score),
        .lives_out     (lives),
        .game_over_out (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        hcount = 11'd1023;
        vcount = 10'd767;
        step();
        hcount = 11'd0;
        vcount = 10'd0;
    endtask

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; start = 1'b0; hit = 1'b0; miss = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_serve", 32'(serve), 0);
        chk("rst_over", 32'(game_over), 0);

        rst = 1'b0;
        step();
        chk("idle_hold", 32'(state), 0);

        start = 1'b1;
        step();
        chk("start_serve", 32'(state), 1);
        frame();
        chk("serve_f1_pulse", 32'(serve), 0);
        chk("serve_f1_state", 32'(state), 1);
        frame();
        chk("serve_f2_pulse", 32'(serve), 1);
        chk("serve_f2_state", 32'(state), 2);
        chk("serve_f2_tick", 32'(tick), 0);
        step();
        chk("serve_pulse_end", 32'(serve), 0);

        // 12 frames in PLAY: ticks after frames 4, 8, 12 only
        for (int f = 1; f <= 12; f++) begin
            frame();
            if (tick) n_ticks++;
            chk($sformatf("tick_f%0d", f), 32'(tick), (f % 4 == 0) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("tick_gap_f%0d", f), 32'(tick), 0);
        end
        chk("tick_total", 32'(n_ticks), 3);
        chk("start_held_play", 32'(state), 2);

        for (int i = 0; i < 10; i++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            step();
        end
        chk("score_10", 32'(score), 10);

        // hit + miss on the tick-generating frame_end
        frame();
        frame();
        frame();
        hit = 1'b1;
        miss = 1'b1;
        frame();
        hit = 1'b0;
        miss = 1'b0;
        chk("combo_lives", 32'(lives), 2);
        chk("combo_score", 32'(score), 10);
        chk("combo_tick", 32'(tick), 0);
        chk("combo_state", 32'(state), 1);
        step();
        chk("combo_tick_after", 32'(tick), 0);

        frame();
        frame();
        chk("reserve1_state", 32'(state), 2);
        chk("reserve1_pulse", 32'(serve), 1);

        for (int i = 0; i < 300; i++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            step();
        end
        chk("score_sat", 32'(score), 255);

        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("miss2_lives", 32'(lives), 1);
        chk("miss2_state", 32'(state), 1);
        chk("miss2_score", 32'(score), 255);
        frame();
        frame();
        chk("reserve2_state", 32'(state), 2);

        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("miss3_lives", 32'(lives), 0);
        chk("miss3_state", 32'(state), 3);
        chk("miss3_over", 32'(game_over), 1);
        frame();
        chk("over_no_tick", 32'(tick), 0);
        chk("over_hold", 32'(state), 3);

        start = 1'b0;
        step();
        chk("over_no_rise", 32'(state), 3);
        start = 1'b1;
        step();
        chk("restart_state", 32'(state), 1);
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_over", 32'(game_over), 0);

        frame();
        frame();
        chk("play3_state", 32'(state), 2);
        for (int i = 0; i < 10; i++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            step();
        end
        chk("pre_rst_score", 32'(score), 10);
        frame();
        frame();

        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_lives", 32'(lives), 3);
        chk("midrst_tick", 32'(tick), 0);
        chk("midrst_serve", 32'(serve), 0);
        n_ticks = 0;
        for (int f = 0; f < 5; f++) begin
            frame();
            if (tick || serve) n_ticks++;
        end
        chk("post_rst_no_pulses", 32'(n_ticks), 0);
        chk("post_rst_idle", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_sequencer.md
# pong_sequencer

Game-phase controller for the pong datapath. Derives frame boundaries from the pixel counters, decides when the puck/paddle update logic may move (one `tick_out` per N frames), and sequences the round: idle, serve delay, play, game over. Tracks score and lives from hit/miss events reported by the datapath. Its outputs gate and relaunch the pong datapath and drive the score overlay.

## Interface
- `H_LAST`, 1023: hcount value of the last pixel in a frame.
- `V_LAST`, 767: vcount value of the last line in a frame.
- `FRAMES_PER_TICK`, 4: frames per movement tick, range 1..15.
- `SERVE_FRAMES`, 60: frames of serve delay before the puck launches, range 1..255.
- `LIVES`, 3: lives at game start, range 1..15.
- `pixel_clk_in`, in, 1: the only clock. All logic is on its rising edge.
- `rst_in`, in, 1: synchronous, active-high reset.
- `hcount_in`, in, 11: pixel column.
- `vcount_in`, in, 10: pixel row.
- `start_in`, in, 1: start button, level. Only its rising edge is used.
- `hit_in`, in, 1: one-cycle pulse when the puck strikes the paddle.
- `miss_in`, in, 1: one-cycle pulse when the puck passes the paddle.
- `tick_out`, out, 1: one-cycle movement enable for the datapath.
- `serve_out`, out, 1: one-cycle pulse telling the datapath to re-randomize and launch the puck.
- `state_out`, out, 2: current phase. IDLE=0, SERVE=1, PLAY=2, OVER=3.
- `score_out`, out, 8: hit count, saturating at 255.
- `lives_out`, out, 4: remaining lives.
- `game_over_out`, out, 1: high while in OVER.

## Operation
- `frame_end` is true in the cycle where `hcount_in==H_LAST && vcount_in==V_LAST`. It is combinational and internal.
- Start edge detection:
  - `start_q` registers `start_in`.
  - `start_rise = start_in & ~start_q`.
  - Reset clears `start_q` to 0. A button already held at reset therefore produces one rise on the first cycle after reset.
- FSM behaviour:
  - **IDLE**: on `start_rise`, go to SERVE. Load score=0, lives=LIVES, serve counter=0.
  - **SERVE**:
    - Each `frame_end` increments the serve counter.
    - On the frame_end that brings the count to SERVE_FRAMES, go to PLAY, pulse `serve_out` for one cycle, and clear the tick counter.
  - **PLAY**:
    - Each `frame_end` increments the tick counter.
    - On the FRAMES_PER_TICK-th frame_end, pulse `tick_out` and wrap the counter to 0.
    - `hit_in`: score +1, saturating at 255.
    - `miss_in`: lives -1. If the resulting value is 0, go to OVER. Otherwise go to SERVE, clear the serve counter, and suppress any `tick_out` for that cycle.
  - **OVER**: `game_over_out`=1. On `start_rise`, go to SERVE with score=0, lives=LIVES, serve counter=0.
- Simultaneous events:
  - `hit_in` and `miss_in` in the same cycle: the miss is applied and the hit is dropped.
  - `miss_in` coinciding with the tick-generating frame_end: the miss wins and no tick is issued.
- `hit_in` and `miss_in` are ignored outside PLAY.
- `start_rise` is ignored in SERVE and PLAY. Restart mid-game is only via `rst_in`.
- All counters are sized to their parameter range and never wrap past the terminal value.

## Timing
- Reset values:
  - state IDLE.
  - `tick_out`=0, `serve_out`=0.
  - `score_out`=0, `lives_out`=LIVES.
  - `game_over_out`=0, `state_out`=0.
  - All counters 0.
- `rst_in` takes priority in any state, including mid-serve and mid-play, and takes effect on the next edge.
- All outputs are registered.
- `tick_out` and `serve_out` are high exactly in the cycle after the matching frame_end cycle.
- `state_out`, `score_out` and `lives_out` update in the cycle after the triggering input pulse.
- First `tick_out` after launch:
  - It occurs FRAMES_PER_TICK frames after `serve_out`.
  - The frame_end that generated `serve_out` does not count toward it.
- `serve_out` and `tick_out` are never high in the same cycle.

## Structure
- Shared package `pong_pkg`:
  - `game_state_t` enum (IDLE, SERVE, PLAY, OVER, 2 bits).
  - Default `H_LAST`/`V_LAST` constants, reused by the pong datapath and the video timing.
- One sub-module, `frame_divider`:
  - Inputs: clock, sync reset, `clear`, `frame_end`.
  - Parameter: `N`.
  - Output: registered one-cycle `pulse` on every Nth frame_end.
  - Instantiated twice: once with N=FRAMES_PER_TICK for the tick, once with N=SERVE_FRAMES for the serve delay.
  - Clear is driven by the FSM on state entry.

## Test plan
- Reset, then raise `start_in` and hold it:
  - SERVE is entered one cycle later.
  - With SERVE_FRAMES=2, `serve_out` pulses once, one cycle after the 2nd frame_end.
  - `state_out` becomes 2.
  - Holding `start_in` causes no further transitions.
- PLAY with FRAMES_PER_TICK=4 over 12 frames:
  - Exactly 3 `tick_out` pulses, each one cycle after frame_end cycles 4, 8 and 12.
- 300 `hit_in` pulses in PLAY: `score_out` saturates at 255.
- LIVES=3, three `miss_in` pulses, each after the following serve:
  - `lives_out` steps 2, 1, 0.
  - The third miss gives `state_out`=3 and `game_over_out`=1.
  - A subsequent `start_rise` gives score 0, lives 3 and SERVE.
- `hit_in`+`miss_in` in the same cycle, on the tick-generating frame_end:
  - Lives decrement and score is unchanged.
  - No `tick_out`; state goes to SERVE.
- `rst_in` asserted mid-PLAY with score 10:
  - Next cycle: IDLE, score 0, lives LIVES, all pulses low.
  - Ticks stay suppressed until the next start.
